// File: rtl/display_scan_if.sv
// Bundle between the calculator core (master) and the display scan controller (slave).
// Core drives value/load/sel; the scanner returns the digit stream and status.
interface display_scan_if;
  logic [15:0] value;
  logic        load;
  logic        sel;
  logic [3:0]  digit;
  logic        mode;
  logic [3:0]  an;
  logic        busy;
  logic        overflow;
  logic        state_dbg;

  // load is a single-cycle strobe; it is only honoured while busy is low.
  modport master (output value, load, sel,
                  input  digit, mode, an, busy, overflow, state_dbg);
  modport slave  (input  value, load, sel,
                  output digit, mode, an, busy, overflow, state_dbg);
endinterface

// File: rtl/display_scan.sv
// Four-digit seven-segment scan controller with a sequential shift-and-add-3
// binary-to-BCD converter and leading-zero blanking in decimal mode.
module display_scan #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic          clk,
  input  logic          rst,
  display_scan_if.slave bus
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {S_IDLE, S_CONVERT} state_t;

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [15:0]         bin_q, bin_d;
  logic [15:0]         bcd_q, bcd_d;
  logic [4:0]          cnt_q, cnt_d;
  logic                mode_q, mode_d;
  logic                ovf_q, ovf_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic [1:0]          idx_q, idx_d;

  logic [15:0] bcd_adj;
  logic [15:0] bcd_shift;
  logic [3:0]  blank;

  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 4; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                     : bcd_q[4*i +: 4];
    end
    // Carry out of the top BCD digit is dropped, which yields value mod 10000.
    bcd_shift = {bcd_adj[14:0], bin_q[15]};
  end

  always_comb begin
    state_d = state_q;
    disp_d  = disp_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          if (bus.sel) begin
            disp_d = bus.value;
            mode_d = 1'b1;
            ovf_d  = 1'b0;
          end else begin
            bin_d   = bus.value;
            bcd_d   = '0;
            cnt_d   = '0;
            mode_d  = 1'b0;
            ovf_d   = (bus.value > 16'd9999);
            state_d = S_CONVERT;
          end
        end
      end
      S_CONVERT: begin
        bcd_d = bcd_shift;
        bin_d = {bin_q[14:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          disp_d  = bcd_shift;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Free-running scan, independent of the conversion FSM.
  always_comb begin
    pre_d = pre_q + PW'(1);
    idx_d = idx_q;
    if (pre_q == PW'(SCAN_DIV - 1)) begin
      pre_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      disp_q  <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      ovf_q   <= 1'b0;
      pre_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      disp_q  <= disp_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
    end
  end

  // Digit i blanks when it and all more-significant digits are zero; digit 0 never does.
  always_comb begin
    blank[3] = (disp_q[15:12] == 4'd0);
    blank[2] = blank[3] && (disp_q[11:8] == 4'd0);
    blank[1] = blank[2] && (disp_q[7:4] == 4'd0);
    blank[0] = 1'b0;
  end

  assign bus.digit     = disp_q[4*idx_q +: 4];
  assign bus.an        = (!mode_q && blank[idx_q]) ? 4'b1111 : ~(4'b0001 << idx_q);
  assign bus.mode      = mode_q;
  assign bus.overflow  = ovf_q;
  assign bus.busy      = (state_q == S_CONVERT);
  assign bus.state_dbg = (state_q == S_CONVERT);
endmodule
